// File: rtl/axi_burst_addr_gen.sv
// Per-beat AXI4 burst address / byte-lane generator for FIXED, INCR and WRAP bursts.
// Optional 4 KB boundary check for INCR commands: define AXI_BURST_4K_CHECK_EN.
module axi_burst_addr_gen #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int ID_WIDTH   = 12,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ID_WIDTH-1:0]   cmd_id,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [7:0]            cmd_len,
    input  logic [2:0]            cmd_size,
    input  logic [1:0]            cmd_burst,
    output logic                  cmd_err,
    output logic                  beat_valid,
    input  logic                  beat_ready,
    output logic [ID_WIDTH-1:0]   beat_id,
    output logic [ADDR_WIDTH-1:0] beat_addr,
    output logic [STRB_WIDTH-1:0] beat_strb,
    output logic [7:0]            beat_num,
    output logic                  beat_last
);

    localparam int AW = ADDR_WIDTH;
    localparam int EW = ADDR_WIDTH + 16;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t                state_r;
    state_t                state_next_s;
    logic [ID_WIDTH-1:0]   id_r;
    logic [AW-1:0]         addr_r;
    logic [STRB_WIDTH-1:0] strb_r;
    logic [7:0]            num_r;
    logic [7:0]            len_r;
    logic [2:0]            size_r;
    logic [1:0]            burst_r;
    logic                  valid_r;
    logic                  last_r;
    logic                  err_r;

    logic                  cmd_fire_s;
    logic                  cmd_legal_s;
    logic                  beat_fire_s;
    logic [AW-1:0]         next_addr_s;
    logic [STRB_WIDTH-1:0] next_strb_s;
    logic [STRB_WIDTH-1:0] start_strb_s;

    function automatic logic [AW-1:0] size_mask_f(input logic [2:0] size);
        return AW'((32'd1 << size) - 32'd1);
    endfunction

    // Lanes from the (possibly unaligned) start byte up to the end of the aligned beat.
    function automatic logic [STRB_WIDTH-1:0] strb_f(input logic [AW-1:0] addr,
                                                     input logic [2:0]    size);
        logic [AW-1:0]         mask;
        logic [AW-1:0]         lo;
        logic [AW-1:0]         hi;
        logic [STRB_WIDTH-1:0] strb;
        mask = size_mask_f(size);
        lo   = addr & AW'(STRB_WIDTH - 1);
        hi   = ((addr & ~mask) + mask) & AW'(STRB_WIDTH - 1);
        strb = '0;
        for (int i = 0; i < STRB_WIDTH; i++) begin
            strb[i] = (AW'(i) >= lo) && (AW'(i) <= hi);
        end
        return strb;
    endfunction

    function automatic logic [AW-1:0] next_addr_f(input logic [AW-1:0] addr,
                                                  input logic [2:0]    size,
                                                  input logic [7:0]    len,
                                                  input logic [1:0]    burst);
        logic [AW-1:0] mask;
        logic [AW-1:0] nb;
        logic [AW-1:0] wsize;
        logic [AW-1:0] lo;
        logic [AW-1:0] inc;
        logic [AW-1:0] nxt;
        mask  = size_mask_f(size);
        nb    = mask + AW'(1);
        wsize = (AW'(len) + AW'(1)) << size;
        lo    = addr & ~(wsize - AW'(1));
        inc   = addr + nb;
        case (burst)
            2'd0:    nxt = addr;
            2'd1:    nxt = (addr & ~mask) + nb;
            2'd2:    nxt = (inc == (lo + wsize)) ? lo : inc;
            default: nxt = addr;
        endcase
        return nxt;
    endfunction

    function automatic logic legal_f(input logic [AW-1:0] addr,
                                     input logic [7:0]    len,
                                     input logic [2:0]    size,
                                     input logic [1:0]    burst);
        logic size_ok;
        logic wrap_ok;
        logic bound_ok;
`ifdef AXI_BURST_4K_CHECK_EN
        logic [EW-1:0] first;
        logic [EW-1:0] final_b;
        first    = EW'(addr & ~size_mask_f(size));
        final_b  = first + ((EW'(len) + EW'(1)) << size) - EW'(1);
        bound_ok = (burst != 2'd1) || (first[EW-1:12] == final_b[EW-1:12]);
`else
        bound_ok = 1'b1;
`endif
        size_ok = (32'd1 << size) <= 32'(STRB_WIDTH);
        wrap_ok = (burst != 2'd2) ||
                  (((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15)) &&
                   ((addr & size_mask_f(size)) == '0));
        return size_ok && (burst != 2'd3) && wrap_ok && bound_ok;
    endfunction

    assign cmd_ready    = (state_r == ST_IDLE) && aresetn;
    assign cmd_fire_s   = cmd_valid && cmd_ready;
    assign cmd_legal_s  = legal_f(cmd_addr, cmd_len, cmd_size, cmd_burst);
    assign beat_fire_s  = valid_r && beat_ready;
    assign next_addr_s  = next_addr_f(addr_r, size_r, len_r, burst_r);
    assign next_strb_s  = strb_f(next_addr_s, size_r);
    assign start_strb_s = strb_f(cmd_addr, cmd_size);

    assign cmd_err    = err_r;
    assign beat_valid = valid_r;
    assign beat_id    = id_r;
    assign beat_addr  = addr_r;
    assign beat_strb  = strb_r;
    assign beat_num   = num_r;
    assign beat_last  = last_r;

    // State register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode: legal command enters BURST, last-beat handshake leaves it.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (cmd_fire_s && cmd_legal_s) begin
                    state_next_s = ST_BURST;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_BURST: begin
                if (beat_fire_s && last_r) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_BURST;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Beat descriptor registers; they hold while the consumer stalls.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            id_r    <= '0;
            addr_r  <= '0;
            strb_r  <= '0;
            num_r   <= 8'd0;
            len_r   <= 8'd0;
            size_r  <= 3'd0;
            burst_r <= 2'd0;
            valid_r <= 1'b0;
            last_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            err_r <= cmd_fire_s && !cmd_legal_s;
            case (state_r)
                ST_IDLE: begin
                    if (cmd_fire_s && cmd_legal_s) begin
                        id_r    <= cmd_id;
                        addr_r  <= cmd_addr;
                        strb_r  <= start_strb_s;
                        num_r   <= 8'd0;
                        len_r   <= cmd_len;
                        size_r  <= cmd_size;
                        burst_r <= cmd_burst;
                        valid_r <= 1'b1;
                        last_r  <= (cmd_len == 8'd0);
                    end else begin
                        valid_r <= 1'b0;
                        last_r  <= 1'b0;
                    end
                end
                ST_BURST: begin
                    if (beat_fire_s && last_r) begin
                        valid_r <= 1'b0;
                        last_r  <= 1'b0;
                    end else if (beat_fire_s) begin
                        num_r  <= num_r + 8'd1;
                        addr_r <= next_addr_s;
                        strb_r <= next_strb_s;
                        last_r <= ((num_r + 8'd1) == len_r);
                    end else begin
                        valid_r <= valid_r;
                    end
                end
                default: begin
                    valid_r <= 1'b0;
                    last_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule
